// File: rtl/mc_control_if.sv
// mc_control_if: control-unit bundle between the multicycle sequencer and its datapath
interface mc_control_if #(
    parameter int OPW = 4
);
    logic [OPW-1:0] opcode;
    logic           zero;
    logic           mem_ready;
    logic           pc_write;
    logic [1:0]     pc_src;
    logic           ir_write;
    logic           mem_read;
    logic           mem_write;
    logic           reg_write;
    logic [1:0]     wb_sel;
    logic           out_write;
    logic           halted;
    logic [2:0]     state;
    modport master (
        output opcode, zero, mem_ready,
        input  pc_write, pc_src, ir_write, mem_read, mem_write, reg_write, wb_sel, out_write, halted, state
    );
    modport slave (
        input  opcode, zero, mem_ready,
        output pc_write, pc_src, ir_write, mem_read, mem_write, reg_write, wb_sel, out_write, halted, state
    );
endinterface

// File: rtl/mc_control.sv
// mc_control: multicycle CPU sequencer with Moore strobes decoded from state and opcode.
// Define MEM_WAIT_EN to stall FETCH/MEM until mem_ready.
module mc_control #(
    parameter int OPW = 4
) (
    input logic         clk,
    input logic         rst,
    mc_control_if.slave bus
);
    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5
    } state_e;
    localparam logic [OPW-1:0] OP_ADD  = 4'h0;
    localparam logic [OPW-1:0] OP_IN   = 4'h1;
    localparam logic [OPW-1:0] OP_OUT  = 4'h2;
    localparam logic [OPW-1:0] OP_LW   = 4'h3;
    localparam logic [OPW-1:0] OP_SW   = 4'h4;
    localparam logic [OPW-1:0] OP_BEQ  = 4'h5;
    localparam logic [OPW-1:0] OP_JMP  = 4'h6;
    localparam logic [OPW-1:0] OP_HALT = 4'hF;
    state_e         state_q, state_d;
    logic [OPW-1:0] op;
    logic           ready, act, is_nop, take_br;
    assign op = bus.opcode;
`ifdef MEM_WAIT_EN
    assign ready = bus.mem_ready;
`else
    logic mem_ready_unused;
    assign mem_ready_unused = bus.mem_ready;
    assign ready = 1'b1;
`endif
    // rst masks every output combinationally so the reset cycle itself is quiet
    assign act     = !rst;
    assign is_nop  = op > OP_JMP && op != OP_HALT;
    assign take_br = op == OP_BEQ && bus.zero;
    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH:   state_d = ready ? DECODE : FETCH;
            DECODE:  state_d = op == OP_IN ? WB : op == OP_HALT ? HALT : is_nop ? FETCH : EXEC;
            EXEC:    state_d = op == OP_ADD ? WB : (op == OP_LW || op == OP_SW) ? MEM : FETCH;
            MEM:     state_d = !ready ? MEM : op == OP_LW ? WB : FETCH;
            WB:      state_d = FETCH;
            HALT:    state_d = HALT;
            default: state_d = FETCH;
        endcase
    end
    always_ff @(posedge clk) begin
        state_q <= rst ? FETCH : state_d;
    end
    assign bus.mem_read  = act && (state_q == FETCH || (state_q == MEM && op == OP_LW));
    assign bus.mem_write = act && state_q == MEM && op == OP_SW;
    assign bus.ir_write  = act && state_q == FETCH && ready;
    assign bus.pc_write  = act && ((state_q == FETCH && ready) ||
                                   (state_q == EXEC && (take_br || op == OP_JMP)));
    assign bus.pc_src    = !(act && state_q == EXEC) ? 2'b00 :
                           op == OP_JMP ? 2'b10 : take_br ? 2'b01 : 2'b00;
    assign bus.out_write = act && state_q == EXEC && op == OP_OUT;
    assign bus.reg_write = act && state_q == WB && (op == OP_ADD || op == OP_LW || op == OP_IN);
    assign bus.wb_sel    = !(act && state_q == WB) ? 2'b00 :
                           op == OP_LW ? 2'b01 : op == OP_IN ? 2'b10 : 2'b00;
    assign bus.halted    = act && state_q == HALT;
    assign bus.state     = act ? state_q : FETCH;
endmodule

// File: doc/mc_control.md
MC_CONTROL -- requirements
Module: mc_control

Interface
REQ-001 Parameter: OPW, default 4, opcode width taken from IR[15:12]; only 4 is supported.
REQ-002 clock  input  1  rising-edge system clock.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 opcode  input  OPW  current IR opcode field.
REQ-005 zero  input  1  ALU zero flag, valid in EXEC.
REQ-006 mem_ready  input  1  memory access complete; used only when MEM_WAIT_EN is defined.
REQ-007 pc_write  output  1  PC load strobe.
REQ-008 pc_src  output  2  PC source: 00 PC+1, 01 branch target, 10 jump target.
REQ-009 ir_write  output  1  IR load strobe.
REQ-010 mem_read / mem_write  output  1 each  memory read and write strobes.
REQ-011 reg_write  output  1  register file write strobe.
REQ-012 wb_sel  output  2  write-back source: 00 ALU, 01 memory data, 10 read_in.
REQ-013 out_write  output  1  write_out register load strobe.
REQ-014 halted  output  1  high while in HALT.
REQ-015 state  output  3  current state code, for debug.

Function
REQ-016 States and codes SHALL be FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5; codes 6-7 SHALL go to FETCH on the next edge.
REQ-017 Opcode map SHALL be: 0 ADD, 1 IN, 2 OUT, 3 LW, 4 SW, 5 BEQ, 6 JMP, F HALT; 7-E are NOPs.
REQ-018 FETCH SHALL assert mem_read, ir_write and pc_write with pc_src=00, then go to DECODE.
REQ-019 DECODE SHALL assert no strobes; next state: IN->WB; HALT->HALT; NOP->FETCH; all other opcodes->EXEC.
REQ-020 EXEC transitions: ADD->WB; LW and SW->MEM; OUT, BEQ and JMP->FETCH.
REQ-021 EXEC strobes: OUT asserts out_write; BEQ asserts pc_write with pc_src=01 only when zero=1; JMP asserts pc_write with pc_src=10.
REQ-022 MEM: LW asserts mem_read then goes to WB; SW asserts mem_write then goes to FETCH.
REQ-023 WB SHALL assert reg_write with wb_sel=00 for ADD, 01 for LW and 10 for IN, then go to FETCH.
REQ-024 Strobes are Moore outputs decoded from state and opcode; outside the cases above every strobe is 0 and pc_src/wb_sel are 00.
REQ-025 Cycles per instruction SHALL be: IN, OUT, BEQ, JMP = 3; ADD, SW = 4; LW = 5; NOP = 2.
REQ-026 HALT SHALL assert halted, hold all strobes at 0, and be left only by rst.
REQ-027 At most one of mem_read and mem_write SHALL be high in any cycle.

Reset
REQ-028 While rst is high at a rising edge, the next state SHALL be FETCH regardless of the current state, including mid-instruction and HALT.
REQ-029 While rst is high, all strobes and halted SHALL be forced to 0 and state SHALL read 0.
REQ-030 The first cycle after rst falls SHALL be FETCH with the FETCH strobes active.

Configuration
REQ-031 Macro MEM_WAIT_EN: when defined, FETCH and MEM hold their state and keep mem_read/mem_write asserted until mem_ready=1.
REQ-032 With MEM_WAIT_EN, ir_write and pc_write in FETCH SHALL assert only in the cycle where mem_ready=1.
REQ-033 Without MEM_WAIT_EN, mem_ready SHALL be ignored and every memory access takes exactly one cycle.

Verification
REQ-034 rst high 2 cycles, then opcode=0 (ADD) -> state 0,1,2,4,0; reg_write=1 with wb_sel=00 only in cycle 4.
REQ-035 opcode=5 (BEQ) run once with zero=1 and once with zero=0 -> pc_write=1 with pc_src=01 in EXEC only when zero=1; next state FETCH in both runs.
REQ-036 opcode=3 (LW) -> states 0,1,2,3,4; mem_read in MEM; reg_write=1 with wb_sel=01 in WB; mem_write never asserted.
REQ-037 opcode=F -> halted=1 from cycle 3 onward and stays high for 20 cycles; 1-cycle rst -> state=0, halted=0.
REQ-038 rst asserted in MEM of SW -> no mem_write during the rst cycle; next state FETCH.
REQ-039 MEM_WAIT_EN defined, mem_ready held low 3 cycles in FETCH -> state stays 0 and ir_write=0 for those cycles; ir_write=1 in the cycle mem_ready=1.
